// File: rtl/sd_multi_magnitude.sv
// Multi-channel sigma-delta power / magnitude estimator: boxcar decimation, per-channel
// power or alpha-max-beta-min magnitude, leaky smoothing, time-multiplexed output.
module sd_multi_magnitude #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEC_BITS = 6,
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned GAIN     = 8
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               en,
   input  logic                                               mode,
   input  logic [CHANNELS-1:0]                                inSin,
   input  logic [CHANNELS-1:0]                                inCos,
   output logic [WIDTH-1:0]                                   out,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] outCh,
   output logic                                               outValid
);

   localparam int unsigned CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned AW  = DEC_BITS + 2;      // signed window sum
   localparam int unsigned MW  = DEC_BITS + 1;      // |sum|
   localparam int unsigned PW  = 2 * DEC_BITS + 2;  // s^2 + c^2
   localparam int unsigned MDW = DEC_BITS + 2;      // max + min/4 + min/8
   localparam int unsigned FW  = WIDTH + GAIN;
   localparam int unsigned SW  = FW + 1;
   localparam int unsigned PSH = WIDTH - 2 * DEC_BITS - 2;
   localparam int unsigned MSH = WIDTH - DEC_BITS - 1;

   localparam logic signed [AW-1:0] ONE     = AW'(1);
   localparam logic signed [AW-1:0] NEG_ONE = '1;
   localparam logic [CW-1:0]        LAST_CH = CW'(CHANNELS - 1);

   typedef enum logic {StIdle, StProc} state_e;

   // ---------------------------------------------------------------- decimation
   logic [DEC_BITS-1:0]   cnt_q, cnt_d;
   logic signed [AW-1:0]  acc_s_q [CHANNELS];
   logic signed [AW-1:0]  acc_c_q [CHANNELS];
   logic signed [AW-1:0]  acc_s_d [CHANNELS];
   logic signed [AW-1:0]  acc_c_d [CHANNELS];
   logic signed [AW-1:0]  sum_s   [CHANNELS];
   logic signed [AW-1:0]  sum_c   [CHANNELS];
   logic signed [AW-1:0]  snap_s_q [CHANNELS];
   logic signed [AW-1:0]  snap_c_q [CHANNELS];
   logic                  e0;
   logic                  mode_q;
   logic                  mode_chg;

   assign e0       = en && (cnt_q == '1);
   assign mode_chg = e0 && (mode != mode_q);

   // The closing sample goes into the snapshot; accumulators restart from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = cnt_q + 1'b1;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         sum_s[i]   = acc_s_q[i] + (inSin[i] ? ONE : NEG_ONE);
         sum_c[i]   = acc_c_q[i] + (inCos[i] ? ONE : NEG_ONE);
         acc_s_d[i] = acc_s_q[i];
         acc_c_d[i] = acc_c_q[i];
         if (en) begin
            acc_s_d[i] = e0 ? '0 : sum_s[i];
            acc_c_d[i] = e0 ? '0 : sum_c[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         mode_q <= 1'b0;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            acc_s_q[i]  <= '0;
            acc_c_q[i]  <= '0;
            snap_s_q[i] <= '0;
            snap_c_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            acc_s_q[i] <= acc_s_d[i];
            acc_c_q[i] <= acc_c_d[i];
         end
         if (e0) begin
            mode_q <= mode;
            for (int i = 0; i < int'(CHANNELS); i++) begin
               snap_s_q[i] <= sum_s[i];
               snap_c_q[i] <= sum_c[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------- channel sequencer
   state_e        state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;
   logic          proc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // A new window boundary always restarts the sweep, even mid-sweep.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (e0) begin
         state_d = StProc;
         idx_d   = '0;
      end else if (state_q == StProc) begin
         if (idx_q == LAST_CH) begin
            state_d = StIdle;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_comb begin
      proc = (state_q == StProc);
   end

   // ---------------------------------------------------------------- stage 1
   logic signed [AW-1:0] sel_s, sel_c;
   logic signed [AW-1:0] neg_s, neg_c;
   logic [MW-1:0]        abs_s, abs_c, max_v, min_v;
   logic [PW-1:0]        pa, pb, pwr;
   logic [MDW-1:0]       mag;
   logic [WIDTH-1:0]     x_d;

   logic                 s1_valid_q;
   logic [CW-1:0]        s1_ch_q;
   logic [WIDTH-1:0]     s1_x_q;

   always_comb begin
      sel_s = snap_s_q[idx_q];
      sel_c = snap_c_q[idx_q];
      neg_s = -sel_s;
      neg_c = -sel_c;
      abs_s = MW'(sel_s[AW-1] ? neg_s : sel_s);
      abs_c = MW'(sel_c[AW-1] ? neg_c : sel_c);
      max_v = (abs_s > abs_c) ? abs_s : abs_c;
      min_v = (abs_s > abs_c) ? abs_c : abs_s;
      pa    = PW'(abs_s);
      pb    = PW'(abs_c);
      pwr   = pa * pa + pb * pb;
      mag   = MDW'(max_v) + MDW'(min_v >> 2) + MDW'(min_v >> 3);
      x_d   = mode_q ? (WIDTH'(mag) << MSH) : (WIDTH'(pwr) << PSH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_ch_q    <= '0;
         s1_x_q     <= '0;
      end else begin
         s1_valid_q <= proc;
         if (proc) begin
            s1_ch_q <= idx_q;
            s1_x_q  <= x_d;
         end
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic [FW-1:0]    filt_q [CHANNELS];
   logic [FW-1:0]    filt_cur;
   logic [SW-1:0]    filt_sum;
   logic [FW-1:0]    filt_nxt;
   logic [WIDTH-1:0] filt_out;

   logic [WIDTH-1:0] out_q;
   logic [CW-1:0]    out_ch_q;
   logic             out_valid_q;

   always_comb begin
      filt_cur = filt_q[s1_ch_q];
      filt_sum = SW'(filt_cur) + SW'(s1_x_q) - SW'(filt_cur >> GAIN);
      filt_nxt = FW'(filt_sum);
      filt_out = WIDTH'(filt_nxt >> GAIN);
   end

   // A mode switch wipes the filter history so old-scale state never blends in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(CHANNELS); i++) filt_q[i] <= '0;
      end else if (mode_chg) begin
         for (int i = 0; i < int'(CHANNELS); i++) filt_q[i] <= '0;
      end else if (s1_valid_q) begin
         filt_q[s1_ch_q] <= filt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q       <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_q    <= filt_out;
            out_ch_q <= s1_ch_q;
         end
      end
   end

   assign out      = out_q;
   assign outCh    = out_ch_q;
   assign outValid = out_valid_q;

endmodule

// File: tb/tb_sd_multi_magnitude.sv
// Bench for sd_multi_magnitude: GAIN=0 and GAIN=8 instances share stimulus and are
// scored cycle by cycle against a window-level arithmetic model.
module tb_sd_multi_magnitude;

   localparam int CH = 2;
   localparam int DB = 6;
   localparam int W  = 16;
   localparam int N  = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          mode = 1'b0;
   logic [CH-1:0] in_sin = '0;
   logic [CH-1:0] in_cos = '0;
   logic [W-1:0]  out0, out8;
   logic [0:0]    och0, och8;
   logic          v0, v8;

   always #5 clk = ~clk;

   sd_multi_magnitude #(.CHANNELS(CH), .DEC_BITS(DB), .WIDTH(W), .GAIN(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .inSin(in_sin), .inCos(in_cos),
      .out(out0), .outCh(och0), .outValid(v0)
   );

   sd_multi_magnitude #(.CHANNELS(CH), .DEC_BITS(DB), .WIDTH(W), .GAIN(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .inSin(in_sin), .inCos(in_cos),
      .out(out8), .outCh(och8), .outValid(v8)
   );

   typedef struct {int due; int ch; int o0; int o8;} exp_t;

   exp_t   expq[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   int     cyc = 0;
   int     cnt_m;
   int     ones_s[CH];
   int     ones_c[CH];
   bit     mode_lat;
   longint facc[CH];
   int     last0, last8, lastch;
   bit     mon_en = 0, first_pend = 0, sw_pend = 0;
   int     prev_ch0 = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      expq.delete();
      cnt_m    = 0;
      mode_lat = 1'b0;
      for (int k = 0; k < CH; k++) begin
         ones_s[k] = 0;
         ones_c[k] = 0;
         facc[k]   = 0;
      end
      last0  = 0;
      last8  = 0;
      lastch = 0;
   endtask

   // Window result from counts of ones: sum = ones - zeros.
   function automatic int xval(input int os, input int oc, input bit md);
      int s, c, a, b, mx, mn;
      s = 2 * os - N;
      c = 2 * oc - N;
      if (!md) return (s * s + c * c) << (W - 2 * DB - 2);
      a  = (s < 0) ? -s : s;
      b  = (c < 0) ? -c : c;
      mx = (a > b) ? a : b;
      mn = (a > b) ? b : a;
      return (mx + mn / 4 + mn / 8) << (W - DB - 1);
   endfunction

   task automatic step(input bit e, input logic [CH-1:0] s, input logic [CH-1:0] c);
      int x;
      en     = e;
      in_sin = s;
      in_cos = c;
      if (e) begin
         for (int k = 0; k < CH; k++) begin
            ones_s[k] += int'(s[k]);
            ones_c[k] += int'(c[k]);
         end
         if (cnt_m == N - 1) begin
            if (mode != mode_lat) for (int k = 0; k < CH; k++) facc[k] = 0;
            mode_lat = mode;
            for (int k = 0; k < CH; k++) begin
               x = xval(ones_s[k], ones_c[k], mode_lat);
               facc[k] = facc[k] + x - (facc[k] >>> 8);
               expq.push_back('{cyc + 3 + k, k, x, int'(facc[k] >>> 8)});
               ones_s[k] = 0;
               ones_c[k] = 0;
            end
            cnt_m = 0;
         end else begin
            cnt_m++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0 && expq[0].due == cyc) begin
         chk("valid_g0", v0, 1);
         chk("valid_g8", v8, 1);
         chk("ch_g0", och0, expq[0].ch);
         chk("ch_g8", och8, expq[0].ch);
         chk("out_g0", out0, expq[0].o0);
         chk("out_g8", out8, expq[0].o8);
         if (expq[0].ch == 0) begin
            if (first_pend) begin
               chk("filt_first", out8, 64);
               first_pend = 0;
            end
            if (mon_en) begin
               chk("filt_mono", out8 >= prev_ch0, 1);
               chk("filt_bound", out8 <= 16384, 1);
               prev_ch0 = int'(out8);
            end
            if (sw_pend) begin
               chk("switch_first", out8, 128);
               sw_pend = 0;
            end
         end
         last0  = expq[0].o0;
         last8  = expq[0].o8;
         lastch = expq[0].ch;
         void'(expq.pop_front());
      end else begin
         chk("idle_g0", v0, 0);
         chk("idle_g8", v8, 0);
         chk("hold_g0", out0, last0);
         chk("hold_g8", out8, last8);
         chk("hold_ch", och0, lastch);
      end
   endtask

   // kind 0: ch0 all ones, ch1 sin zeros / cos alternating; kind 1: random;
   // kind 2: ch0 sin zeros / cos alternating, ch1 all ones.
   // gaps 0: en held, 1: 50% duty, 2: random gaps. Mode flips before sample sw_at.
   task automatic window(input int kind, input int gaps, input int sw_at, input bit mark);
      logic [CH-1:0] s, c;
      for (int i = 0; i < N; i++) begin
         if (i == sw_at) begin
            mode = !mode;
            if (mark) sw_pend = 1;
         end
         if (gaps == 1) step(1'b0, CH'($urandom), CH'($urandom));
         if (gaps == 2) while ($urandom_range(3) == 0) step(1'b0, CH'($urandom), CH'($urandom));
         case (kind)
            0: begin
               s = 2'b01;
               c = {~i[0], 1'b1};
            end
            1: begin
               s = CH'($urandom);
               c = CH'($urandom);
            end
            default: begin
               s = 2'b10;
               c = {1'b1, ~i[0]};
            end
         endcase
         step(1'b1, s, c);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 5; i++) step(1'b0, '0, '0);
   endtask

   task automatic mid_reset();
      rst = 1'b0;
      #2;
      chk("rst_out_g0", out0, 0);
      chk("rst_out_g8", out8, 0);
      chk("rst_ch_g0", och0, 0);
      chk("rst_ch_g8", och8, 0);
      chk("rst_valid_g0", v0, 0);
      chk("rst_valid_g8", v8, 0);
      model_reset();
      #2;
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      #6;
      chk("por_out", out0, 0);
      chk("por_ch", och0, 0);
      chk("por_valid", v0, 0);
      #6;
      rst = 1'b1;

      mode = 1'b0;
      for (int w = 0; w < 3; w++) window(0, 0, -1, 0);
      drain();
      chk("power_ch1", out0, 16384);

      mode = 1'b1;
      for (int w = 0; w < 2; w++) window(0, 0, -1, 0);
      drain();
      chk("mag_ch1", out0, 32768);

      mode = 1'b0;
      for (int w = 0; w < 2; w++) window(0, 1, -1, 0);
      drain();
      chk("duty_ch1", out0, 16384);

      for (int i = 0; i < 20; i++) step(1'b1, 2'b01, 2'b11);
      mid_reset();
      window(0, 0, -1, 0);
      drain();

      for (int w = 0; w < 12; w++)
         window(1, 2, ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1, 0);
      drain();

      mid_reset();
      mode       = 1'b0;
      first_pend = 1;
      mon_en     = 1;
      prev_ch0   = 0;
      for (int w = 0; w < 300; w++) window(2, 0, -1, 0);
      mon_en = 0;
      window(2, 0, 32, 1);
      window(2, 0, -1, 0);
      drain();
      chk("switch_seen", sw_pend, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_multi_magnitude.md
Name: sd_multi_magnitude

Overview:
- Multi-channel successor to the dual sigma-delta magnitude block.
- Takes CHANNELS pairs of 1-bit sigma-delta streams (sin/I and cos/Q).
- Boxcar-decimates each stream over 2^DEC_BITS enabled samples. Per channel, computes power (I²+Q²) or approximate magnitude (alpha-max-beta-min), selectable at run time.
- Smooths each channel with a per-channel leaky integrator and streams results out time-multiplexed with a channel tag.
- Sits between the SigmaDelta2ndOrder front ends and downstream gain-control / level-detect logic.

Parameters:
- CHANNELS, 2, number of sin/cos stream pairs (1..2^DEC_BITS).
- DEC_BITS, 6, log2 of the decimation window length in en-qualified samples.
- WIDTH, 16, output width; must be ≥ 2*DEC_BITS+2.
- GAIN, 8, leaky-filter shift (0 = no filtering).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  sample enable: qualifies inSin/inCos and advances the decimation counter
- mode  in  1  0 = power, 1 = magnitude approximation
- inSin  in  CHANNELS  sigma-delta bit per channel (bit i = channel i)
- inCos  in  CHANNELS  sigma-delta bit per channel
- out  out  WIDTH  filtered result for channel outCh, unsigned
- outCh  out  max(1,$clog2(CHANNELS))  channel index of out
- outValid  out  1  one-clk strobe: out/outCh valid

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - decimation counter, all accumulators, snapshots, filter states, FSM (→IDLE), latched mode;
  - out=0, outCh=0, outValid=0.
- Decode: bit 1 = +1, bit 0 = −1.
- Decimation:
  - Per stream, signed accumulator of DEC_BITS+2 bits; range −2^DEC_BITS..+2^DEC_BITS.
  - On each clk with en=1: accumulator += decoded bit; counter increments modulo 2^DEC_BITS.
  - en=0: accumulators and counter hold.
  - Edge E0 = en=1 edge with counter = 2^DEC_BITS−1 (that sample included). At E0:
    - all 2*CHANNELS sums copied to snapshot registers;
    - accumulators restart at 0, so the next window's first sample is not lost;
    - mode sampled into latched mode;
    - FSM IDLE→PROC, channel index 0.
- FSM IDLE/PROC:
  - PROC advances one channel per clk, independent of en; returns to IDLE after channel CHANNELS−1.
  - CHANNELS ≤ 2^DEC_BITS guarantees PROC finishes before the next E0.
  - If E0 nevertheless arrives in PROC, the snapshot is overwritten and the index restarts at 0 (no hang).
- Stage 1 (registered), on the snapshot pair (s, c):
  - power: p = s²+c², max 2^(2*DEC_BITS+1); x = p << (WIDTH−2*DEC_BITS−2).
  - magnitude: a=|s|, b=|c|; m = max(a,b) + (min>>2) + (min>>3); x = m << (WIDTH−DEC_BITS−1).
  - x is unsigned WIDTH bits and never overflows.
- Stage 2 (registered), per-channel state acc[ch] of WIDTH+GAIN bits:
  - acc ← acc + x − (acc>>GAIN);
  - out = new acc>>GAIN; outCh = ch; outValid=1.
  - Steady state out = x; GAIN=0 gives out = x.
- Latency: channel k's outValid is registered at edge E0+2+k. Exactly CHANNELS strobes per window, in ascending channel order.
- Mode change: if latched mode differs from the previous window's, all acc[] are cleared at E0 before use. The first output after a switch is unsmoothed in the new scale. A mode change mid-window takes effect only at the next E0.
- out/outCh hold their last values between strobes.
- Reset mid-PROC: outputs drop to 0 asynchronously. After release, the first strobe needs a full new window of 2^DEC_BITS en samples.

Test Plan:
All scenarios use defaults except GAIN=0 unless stated.
1. Reset: assert rst=0 mid-window, then release → out=0, outCh=0, outValid=0 immediately; first outValid only after 64 en samples.
2. Power, mode=0: ch0 sin=all 1s, cos=all 1s → out=32768 (8192<<2). ch1 sin=all 0s, cos=alternating 1/0 → out=16384.
3. Magnitude, mode=1, same stimulus as 2 → ch0 out=45056 (88<<9); ch1 out=32768 (64<<9).
4. Timing: outValid at E0+2 with outCh=0 and at E0+3 with outCh=1; exactly 2 strobes per window; en held 1 vs. en 50% duty (128-clk windows) give identical values.
5. Filter, GAIN=8, constant power x=16384:
   - first ch0 strobe out=64; monotonic rise, never exceeding 16384;
   - within 1 LSB scaled tolerance of 16384 after 4096 windows.
6. Mode switch mid-window with GAIN=8 after convergence → unchanged until next E0; first post-switch strobe equals the new-mode x>>8 (state cleared), not a blend.
